// File: rtl/sobel_gradient_if.sv
// sobel_gradient_if
// Pixel-in / gradient-out bundle for the streaming Sobel stage.
//   i_pixel  8-bit unsigned pixel, raster order
//   i_valid  pixel qualifier (gaps allowed, no backpressure)
//   i_sof    with i_valid: current pixel is (row 0, col 0)
//   o_gx     signed 11-bit horizontal gradient
//   o_gy     signed 11-bit vertical gradient
//   o_valid  one-cycle pulse per gradient pair
//   o_eof    marks the last gradient pair of a frame
//   o_mag    |gx|+|gy|, 11-bit unsigned (only when SOBEL_MAG_EN is defined)
// Modports: master = pixel source / gradient sink, slave = the Sobel stage.
// Optional feature macro: SOBEL_MAG_EN.
interface sobel_gradient_if;
  logic [7:0]         i_pixel;
  logic               i_valid;
  logic               i_sof;
  logic signed [10:0] o_gx;
  logic signed [10:0] o_gy;
  logic               o_valid;
  logic               o_eof;
`ifdef SOBEL_MAG_EN
  logic [10:0]        o_mag;

  modport master (output i_pixel, i_valid, i_sof,
                  input  o_gx, o_gy, o_valid, o_eof, o_mag);
  modport slave  (input  i_pixel, i_valid, i_sof,
                  output o_gx, o_gy, o_valid, o_eof, o_mag);
`else
  modport master (output i_pixel, i_valid, i_sof,
                  input  o_gx, o_gy, o_valid, o_eof);
  modport slave  (input  i_pixel, i_valid, i_sof,
                  output o_gx, o_gy, o_valid, o_eof);
`endif
endinterface

// File: rtl/sobel_gradient.sv
// sobel_gradient
// Streaming 3x3 Sobel operator. Two line buffers supply rows r-2 and r-1,
// a 3x3 window shifts one column per accepted pixel, and one registered
// gx/gy pair is emitted per interior pixel, one cycle after the beat that
// completes its window.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset
//   s      sobel_gradient_if.slave (pixel stream in, gradients out)
// Parameters: IMG_WIDTH, IMG_HEIGHT (both >= 3).
// Optional feature macro: SOBEL_MAG_EN adds the registered o_mag = |gx|+|gy|.
module sobel_gradient #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic             i_clk,
  input logic             i_rst,
  sobel_gradient_if.slave s
);
  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Line buffers: lb0 = row r-2, lb1 = row r-1, both indexed by column.
  logic [7:0] lb0 [IMG_WIDTH];
  logic [7:0] lb1 [IMG_WIDTH];

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;

  // A start-of-frame beat is itself (0,0), so the position used this beat
  // is forced before the counters advance past it.
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (s.i_valid && s.i_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (s.i_valid) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Read-before-write on the same address: the old lb1 entry moves down to lb0.
  always_ff @(posedge i_clk) begin
    if (s.i_valid) begin
      lb0[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= s.i_pixel;
    end
  end

  // Incoming window column, top (oldest row) to bottom (current pixel).
  logic [2:0][7:0] new_col;
  assign new_col[0] = lb0[cur_col];
  assign new_col[1] = lb1[cur_col];
  assign new_col[2] = s.i_pixel;

  // win_nx[r][c] is the window as it stands after this beat's shift; the
  // gradient is computed from it so the output register lands one cycle
  // after the completing beat.
  logic [2:0][2:0][7:0] win_nx;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
      logic [2:0][7:0] row_win_q, row_win_d;

      always_comb begin
        row_win_d = row_win_q;
        if (s.i_valid) begin
          row_win_d = {new_col[gi], row_win_q[2], row_win_q[1]};
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) row_win_q <= '0;
        else       row_win_q <= row_win_d;
      end

      assign win_nx[gi] = row_win_d;
    end
  endgenerate

  // 1-2-1 weighted sum of three pixels, at most 1020.
  function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  logic [9:0]         sx_pos, sx_neg, sy_pos, sy_neg;
  logic signed [10:0] gx_raw, gy_raw;

  assign sx_pos = wsum(win_nx[0][2], win_nx[1][2], win_nx[2][2]);
  assign sx_neg = wsum(win_nx[0][0], win_nx[1][0], win_nx[2][0]);
  assign sy_pos = wsum(win_nx[2][0], win_nx[2][1], win_nx[2][2]);
  assign sy_neg = wsum(win_nx[0][0], win_nx[0][1], win_nx[0][2]);
  assign gx_raw = $signed({1'b0, sx_pos}) - $signed({1'b0, sx_neg});
  assign gy_raw = $signed({1'b0, sy_pos}) - $signed({1'b0, sy_neg});

  logic               valid_q, valid_d;
  logic               eof_q, eof_d;
  logic signed [10:0] gx_q, gx_d, gy_q, gy_d;

  // Border centres are excluded by requiring row>=2 and col>=2 on the
  // completing beat; this also keeps stale columns from a line wrap out.
  always_comb begin
    valid_d = s.i_valid && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    eof_d   = valid_d && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    gx_d    = valid_d ? gx_raw : gx_q;
    gy_d    = valid_d ? gy_raw : gy_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
    end else begin
      valid_q <= valid_d;
      eof_q   <= eof_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
    end
  end

  assign s.o_valid = valid_q;
  assign s.o_eof   = eof_q;
  assign s.o_gx    = gx_q;
  assign s.o_gy    = gy_q;

`ifdef SOBEL_MAG_EN
  logic [10:0] gx_abs, gy_abs;
  logic [10:0] mag_q, mag_d;

  // |g| <= 1020, so negation of an 11-bit value never overflows.
  assign gx_abs = gx_raw[10] ? 11'(-gx_raw) : 11'(gx_raw);
  assign gy_abs = gy_raw[10] ? 11'(-gy_raw) : 11'(gy_raw);

  always_comb begin
    mag_d = valid_d ? (gx_abs + gy_abs) : mag_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) mag_q <= '0;
    else       mag_q <= mag_d;
  end

  assign s.o_mag = mag_q;
`endif
endmodule

// File: tb/tb_sobel_gradient.sv
`timescale 1ns/1ps
module tb_sobel_gradient;
  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_gradient_if bus ();

  sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .s     (bus)
  );

  typedef struct {
    int gx;
    int gy;
    int mag;
    bit eof;
    int cyc;
  } out_t;

  typedef struct {
    int p[9];
    int gx;
    int gy;
    int mag;
  } vec_t;

  out_t out_q[$];
  out_t exp_q[$];
  int   img[H][W];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_gx, last_gy;
  bit   have_last = 1'b0;
  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      out_t o;
      o.gx  = int'($signed(bus.o_gx));
      o.gy  = int'($signed(bus.o_gy));
`ifdef SOBEL_MAG_EN
      o.mag = int'(bus.o_mag);
`else
      o.mag = 0;
`endif
      o.eof = bus.o_eof;
      o.cyc = cyc;
      out_q.push_back(o);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Golden Sobel at centre (r,c) of the model image.
  function automatic int model_gx(input int r, input int c);
    return (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
         - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
  endfunction

  function automatic int model_gy(input int r, input int c);
    return (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
         - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sends the first n pixels of img in raster order; queues the expected
  // output (with the edge index it must appear at) for each interior beat.
  task automatic send_pixels(input int n, input bit sof_first, input bit gaps);
    for (int k = 0; k < n; k++) begin
      int r;
      int c;
      r = k / W;
      c = k % W;
      if (gaps) repeat ($urandom_range(0, 1)) idle_cycle();
      bus.i_valid = 1'b1;
      bus.i_pixel = 8'(img[r][c]);
      bus.i_sof   = sof_first && (k == 0);
      idle_cycle();
      if (r >= 2 && c >= 2) begin
        out_t e;
        e.gx  = model_gx(r-1, c-1);
        e.gy  = model_gy(r-1, c-1);
        e.mag = iabs(e.gx) + iabs(e.gy);
        e.eof = (r == H-1) && (c == W-1);
        e.cyc = cyc;
        exp_q.push_back(e);
      end
      bus.i_valid = 1'b0;
      bus.i_sof   = 1'b0;
      bus.i_pixel = 8'h00;
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    repeat (3) idle_cycle();
    chk({tag, "_count"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      out_t a;
      out_t e;
      a = out_q[i];
      e = exp_q[i];
      checks++;
      if (a.gx != e.gx || a.gy != e.gy || a.eof != e.eof || a.cyc != e.cyc
`ifdef SOBEL_MAG_EN
          || a.mag != e.mag
`endif
         ) begin
        failures++;
        $display("FAIL %s_out%0d actual gx=%0d gy=%0d mag=%0d eof=%0d cyc=%0d required gx=%0d gy=%0d mag=%0d eof=%0d cyc=%0d",
                 tag, i, a.gx, a.gy, a.mag, a.eof, a.cyc, e.gx, e.gy, e.mag, e.eof, e.cyc);
      end
    end
    if (exp_q.size() > 0) begin
      last_gx = exp_q[exp_q.size()-1].gx;
      last_gy = exp_q[exp_q.size()-1].gy;
      have_last = 1'b1;
    end
    if (have_last) begin
      chk({tag, "_hold_gx"}, int'($signed(bus.o_gx)), last_gx);
      chk({tag, "_hold_gy"}, int'($signed(bus.o_gy)), last_gy);
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = v;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = int'($urandom_range(0, 255));
  endtask

  initial begin
    // Hand-computed 3x3 patches placed at rows 0-2, cols 0-2 (centre (1,1)).
    vecs[0].p = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    vecs[0].gx = 0;    vecs[0].gy = 0;     vecs[0].mag = 0;
    vecs[1].p = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
    vecs[1].gx = 1020; vecs[1].gy = 0;     vecs[1].mag = 1020;
    vecs[2].p = '{255, 255, 255, 0, 0, 0, 0, 0, 0};
    vecs[2].gx = 0;    vecs[2].gy = -1020; vecs[2].mag = 1020;
    vecs[3].p = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    vecs[3].gx = 8;    vecs[3].gy = 24;    vecs[3].mag = 32;
    vecs[4].p = '{0, 0, 0, 0, 0, 200, 0, 0, 0};
    vecs[4].gx = 400;  vecs[4].gy = 0;     vecs[4].mag = 400;
    vecs[5].p = '{255, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5].gx = -255; vecs[5].gy = -255;  vecs[5].mag = 510;

    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_pixel = 8'h00;
    repeat (3) idle_cycle();
    chk("reset_o_valid", int'(bus.o_valid), 0);
    chk("reset_o_eof",   int'(bus.o_eof), 0);
    chk("reset_o_gx",    int'($signed(bus.o_gx)), 0);
    chk("reset_o_gy",    int'($signed(bus.o_gy)), 0);
`ifdef SOBEL_MAG_EN
    chk("reset_o_mag",   int'(bus.o_mag), 0);
`endif
    rst = 1'b0;
    idle_cycle();

    // Table of patches: first output of each frame is the patch centre.
    for (int v = 0; v < 6; v++) begin
      fill_const(0);
      for (int k = 0; k < 9; k++) img[k/3][k%3] = vecs[v].p[k];
      send_pixels(W*H, 1'b1, 1'b0);
      repeat (2) idle_cycle();
      if (out_q.size() > 0) begin
        chk($sformatf("vec%0d_gx", v), out_q[0].gx, vecs[v].gx);
        chk($sformatf("vec%0d_gy", v), out_q[0].gy, vecs[v].gy);
`ifdef SOBEL_MAG_EN
        chk($sformatf("vec%0d_mag", v), out_q[0].mag, vecs[v].mag);
`endif
      end else begin
        chk($sformatf("vec%0d_present", v), 0, 1);
      end
      check_outputs($sformatf("vec%0d", v));
    end

    // Flat frame; frame boundary via counter wrap (no sof).
    fill_const(100);
    send_pixels(W*H, 1'b0, 1'b0);
    repeat (2) idle_cycle();
    chk("flat_n", out_q.size(), 24);
    if (out_q.size() == 24) begin
      chk("flat_eof23", int'(out_q[23].eof), 1);
      chk("flat_eof22", int'(out_q[22].eof), 0);
      chk("flat_gx5",   out_q[5].gx, 0);
    end
    check_outputs("flat");

    // Vertical step edge between col 3 and col 4.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (c >= 4) ? 255 : 0;
    send_pixels(W*H, 1'b0, 1'b0);
    repeat (2) idle_cycle();
    if (out_q.size() >= 4) begin
      chk("vedge_c3_gx", out_q[2].gx, 1020);
      chk("vedge_c4_gx", out_q[3].gx, 1020);
      chk("vedge_c3_gy", out_q[2].gy, 0);
      chk("vedge_c1_gx", out_q[0].gx, 0);
    end else begin
      chk("vedge_present", out_q.size(), 24);
    end
    check_outputs("vedge");

    // Horizontal step edge between row 2 and row 3.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (r <= 2) ? 255 : 0;
    send_pixels(W*H, 1'b0, 1'b0);
    repeat (2) idle_cycle();
    if (out_q.size() >= 13) begin
      chk("hedge_r2_gy", out_q[6].gy, -1020);
      chk("hedge_r3_gy", out_q[12].gy, -1020);
      chk("hedge_r2_gx", out_q[6].gx, 0);
      chk("hedge_r1_gy", out_q[0].gy, 0);
`ifdef SOBEL_MAG_EN
      chk("hedge_r2_mag", out_q[6].mag, 1020);
      chk("hedge_r3_mag", out_q[12].mag, 1020);
`endif
    end else begin
      chk("hedge_present", out_q.size(), 24);
    end
    check_outputs("hedge");

    // Random frame with random input gaps.
    fill_random();
    send_pixels(W*H, 1'b1, 1'b1);
    check_outputs("rand_gaps");

    // Reset one cycle after pixel (3,5), then a full frame without sof.
    fill_random();
    send_pixels(3*W + 6, 1'b0, 1'b0);
    check_outputs("pre_rst");
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0;
    fill_random();
    send_pixels(W*H, 1'b0, 1'b1);
    check_outputs("post_rst");

    // Frame A aborted by sof where (4,2) would have been, then frame B.
    fill_random();
    send_pixels(4*W + 2, 1'b0, 1'b0);
    check_outputs("abort_a");
    fill_random();
    send_pixels(W*H, 1'b1, 1'b0);
    check_outputs("frame_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
